// File: rtl/pipe_ctrl.sv
// pipe_ctrl: RV32I 5-stage control decode, M/W control pipeline and redirect squash.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int KILL_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] insx_op,
    input  logic        beq,
    output logic        pc_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic [2:0]  imm_sel,
    output logic [3:0]  alu_sel,
    output logic        mem_we,
    output logic [1:0]  wb_sel,
    output logic        RF_we,
    output logic        ill_op,
    output logic [31:0] retire_cnt,
    output logic [31:0] squash_cnt
);
    localparam int KW = $clog2(KILL_DEPTH + 1);

    logic [KW-1:0] kill_cnt;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic legal, squashed, x_valid, bubble, alt;
    logic [3:0] alu_base;
    logic m_mem_we, m_rf_we, w_rf_we;
    logic [1:0] m_wb_sel;
    logic unused_bits;

    assign opc = insx_op[6:0];
    assign rd  = insx_op[11:7];
    assign f3  = insx_op[14:12];
    assign f7  = insx_op[31:25];
    assign unused_bits = ^insx_op[24:15];

    assign is_r     = opc == 7'b0110011;
    assign is_i     = opc == 7'b0010011;
    assign is_lw    = opc == 7'b0000011;
    assign is_sw    = opc == 7'b0100011;
    assign is_br    = opc == 7'b1100011;
    assign is_jal   = opc == 7'b1101111;
    assign is_jalr  = opc == 7'b1100111;
    assign is_lui   = opc == 7'b0110111;
    assign is_auipc = opc == 7'b0010111;

    assign legal = (is_r && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
                || (is_i && (f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1))
                || (is_br && f3[2:1] == 2'b00)
                || is_lw || is_sw || is_jal || is_jalr || is_lui || is_auipc;

    assign squashed = kill_cnt != '0;
    assign x_valid  = !squashed && legal;
    assign bubble   = insx_op == 32'h0;
    assign ill_op   = !squashed && !legal && !bubble;
    assign pc_sel   = x_valid && (is_jal || is_jalr || (is_br && (f3[0] ? !beq : beq)));
    assign a_sel    = is_jal || is_auipc || is_br;
    assign b_sel    = !is_r;
    assign imm_sel  = is_sw ? 3'd1 : is_br ? 3'd2 : is_jal ? 3'd3 : (is_lui || is_auipc) ? 3'd4 : 3'd0;

    always_comb begin
        case (f3)
            3'd0:    alu_base = 4'd0;
            3'd1:    alu_base = 4'd2;
            3'd2:    alu_base = 4'd3;
            3'd3:    alu_base = 4'd4;
            3'd4:    alu_base = 4'd5;
            3'd5:    alu_base = 4'd6;
            3'd6:    alu_base = 4'd8;
            default: alu_base = 4'd9;
        endcase
    end

    // SUB/SRA sit one code above ADD/SRL; OP-IMM only honours funct7[5] on right shifts
    assign alt     = f7[5] && (f3 == 3'd5 || (is_r && f3 == 3'd0));
    assign alu_sel = is_lui ? 4'd10 : (is_r || is_i) ? alu_base + {3'b000, alt} : 4'd0;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            kill_cnt <= '0;
            m_mem_we <= 1'b0;
            m_wb_sel <= 2'b01;
            m_rf_we  <= 1'b0;
            w_rf_we  <= 1'b0;
        end else begin
            kill_cnt <= pc_sel ? KW'(KILL_DEPTH) : squashed ? kill_cnt - 1'b1 : kill_cnt;
            m_mem_we <= x_valid && is_sw;
            m_wb_sel <= is_lw ? 2'b00 : (is_jal || is_jalr) ? 2'b10 : 2'b01;
            m_rf_we  <= x_valid && !is_sw && !is_br && rd != 5'd0;
            w_rf_we  <= m_rf_we;
        end
    end

    assign mem_we = m_mem_we;
    assign wb_sel = m_wb_sel;
    assign RF_we  = w_rf_we;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            retire_cnt <= '0;
            squash_cnt <= '0;
        end else begin
            retire_cnt <= retire_cnt + {31'd0, x_valid};
            squash_cnt <= squash_cnt + {31'd0, squashed && !bubble};
        end
    end
`else
    assign retire_cnt = '0;
    assign squash_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random and directed stimulus against a cycle-level model of the control unit.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rest, beq;
    logic [31:0] insx_op;
    logic        pc_sel, a_sel, b_sel, mem_we, RF_we, ill_op;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_sel;
    logic [1:0]  wb_sel;
    logic [31:0] retire_cnt, squash_cnt;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int checks = 0, errors = 0;
    int kill;
    logic m_mem, m_rf, w_rf;
    logic [1:0] m_wb;
    logic [31:0] rcnt, scnt;

    pipe_ctrl #(.KILL_DEPTH(2)) dut (
        .clk(clk), .rest(rest), .insx_op(insx_op), .beq(beq),
        .pc_sel(pc_sel), .a_sel(a_sel), .b_sel(b_sel), .imm_sel(imm_sel),
        .alu_sel(alu_sel), .mem_we(mem_we), .wb_sel(wb_sel), .RF_we(RF_we),
        .ill_op(ill_op), .retire_cnt(retire_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] i, output logic legal,
                                    output logic [3:0] alu, output logic [2:0] imm);
        int base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        legal = 1'b1;
        alu = 4'd0;
        imm = 3'd0;
        case (i[6:0])
            7'b0110011: begin
                legal = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                alu = 4'(base[f3] + int'(f7[5]));
            end
            7'b0010011: begin
                legal = f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                alu = 4'(base[f3] + int'(f3 == 5 && f7[5]));
            end
            7'b0000011, 7'b1100111: ;
            7'b0100011: imm = 3'd1;
            7'b1100011: begin legal = f3 < 2; imm = 3'd2; end
            7'b1101111: imm = 3'd3;
            7'b0110111: begin alu = 4'd10; imm = 3'd4; end
            7'b0010111: imm = 3'd4;
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        kill = 0; m_mem = 0; m_rf = 0; w_rf = 0; m_wb = 2'b01; rcnt = 0; scnt = 0;
    endtask

    // Drive one instruction for one cycle, check mid-cycle, then advance the model
    task automatic step(input logic [31:0] ins, input logic b);
        logic legal, valid, take, sq;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [6:0] op;
        insx_op = ins;
        beq = b;
        @(negedge clk);
        ref_dec(ins, legal, alu, imm);
        op = ins[6:0];
        sq = kill > 0;
        valid = !sq && legal;
        take = valid && (op == 7'b1101111 || op == 7'b1100111 ||
                         (op == 7'b1100011 && (ins[12] ? !b : b)));
        check("pc_sel", pc_sel, take);
        check("ill_op", ill_op, !sq && !legal && ins != 0);
        check("mem_we", mem_we, m_mem);
        check("wb_sel", wb_sel, m_wb);
        check("RF_we", RF_we, w_rf);
        check("retire_cnt", retire_cnt, PERF ? rcnt : 32'd0);
        check("squash_cnt", squash_cnt, PERF ? scnt : 32'd0);
        if (valid) begin
            check("alu_sel", alu_sel, alu);
            check("imm_sel", imm_sel, imm);
            check("a_sel", a_sel, op == 7'b1101111 || op == 7'b0010111 || op == 7'b1100011);
            check("b_sel", b_sel, op != 7'b0110011);
        end
        w_rf = m_rf;
        m_mem = valid && op == 7'b0100011;
        m_wb = op == 7'b0000011 ? 2'b00 : (op == 7'b1101111 || op == 7'b1100111) ? 2'b10 : 2'b01;
        m_rf = valid && op != 7'b0100011 && op != 7'b1100011 && ins[11:7] != 0;
        rcnt += 32'(valid);
        scnt += 32'(sq && ins != 0);
        kill = take ? 2 : (kill > 0 ? kill - 1 : 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen();
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
        logic [11:0] imm;
        logic [6:0] f7;
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = $urandom_range(0, 5) == 0 ? 5'd0 : 5'($urandom);
        f3  = 3'($urandom);
        imm = 12'($urandom);
        f7  = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 15))
            0:  return {((f3 == 0 || f3 == 5) ? f7 : 7'h00), rs2, rs1, f3, rd, 7'b0110011};
            1:  return {($urandom_range(0, 2) == 0 ? 7'h01 : f7), rs2, rs1, f3, rd, 7'b0110011};
            2:  return {($urandom_range(0, 3) == 0 ? 7'($urandom) : f7), imm[4:0], rs1, f3, rd, 7'b0010011};
            3:  return {imm, rs1, 3'd2, rd, 7'b0000011};
            4:  return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
            5, 6: return {imm[11:5], rs2, rs1, 2'b00, f3[0], imm[4:0], 7'b1100011};
            7:  return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b1100011};
            8:  return {imm, rs1, f3, rd, 7'b1101111};
            9:  return {imm, rs1, 3'd0, rd, 7'b1100111};
            10: return {imm, rs1, f3, rd, 7'b0110111};
            11: return {imm, rs1, f3, rd, 7'b0010111};
            12: return 32'h0;
            13: return {imm, rs1, f3, rd, 7'($urandom)};
            default: return {imm, rs1, 3'd0, rd, 7'b0010011};
        endcase
    endfunction

    initial begin
        rest = 1'b1;
        insx_op = 32'h0;
        beq = 1'b0;
        #3;
        check("rst_pc_sel", pc_sel, 0);
        check("rst_ill_op", ill_op, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_wb_sel", wb_sel, 2'b01);
        check("rst_RF_we", RF_we, 0);
        check("rst_retire", retire_cnt, 0);
        check("rst_squash", squash_cnt, 0);
        @(posedge clk);
        #1;
        rest = 1'b0;
        model_reset();

        step(32'h002081B3, 0);
        step(32'h0020A223, 0);
        step(32'h0, 0);
        step(32'h0, 1);
        step(32'h00208463, 1);
        step(32'h00100293, 0);
        step(32'h00100293, 0);
        step(32'h002081B3, 0);
        step(32'h00209463, 1);
        step(32'h002081B3, 0);
        step(32'h0, 0);
        step(32'h008000EF, 0);
        step(32'h00100293, 0);
        step(32'h00000013, 0);
        step(32'h00000013, 0);
        step(32'h0, 0);
        step(32'h0000007F, 0);
        step(32'h0, 0);
        step(32'h0, 0);

        // Reset one cycle into a redirect window
        step(32'h00100293, 0);
        step(32'h008000EF, 0);
        insx_op = 32'h008000EF;
        #1;
        check("sq_pc_sel", pc_sel, 0);
        check("pre_rst_RF_we", RF_we, 1);
        #1;
        rest = 1'b1;
        #1;
        check("mid_rst_pc_sel", pc_sel, 1);
        check("mid_rst_RF_we", RF_we, 0);
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_wb_sel", wb_sel, 2'b01);
        check("mid_rst_retire", retire_cnt, 0);
        insx_op = 32'h0;
        @(posedge clk);
        #1;
        rest = 1'b0;
        model_reset();

        for (int n = 0; n < 3000; n++) step(gen(), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the 5-stage RV32I datapath (F, D, X, M, W). It decodes the X-stage instruction `insx_op` into execute controls, carries memory and write-back controls down to the M and W stages, and squashes the two wrong-path instructions after any taken branch or jump. There is no hazard or forwarding logic; software schedules around RAW hazards.

## Interface
- `KILL_DEPTH`, default 2: number of younger instructions squashed after a redirect. This equals the F→X distance and must not be changed for this datapath.
- `clk` input 1: rising-edge clock.
- `rest` input 1: asynchronous, active-high reset.
- `insx_op` input 32: instruction currently in X.
- `beq` input 1: X-stage equality flag from the branch comparator.
- `pc_sel` output 1: PC source; 0 = PC+4, 1 = ALU result.
- `a_sel` output 1: ALU A source; 0 = rs1, 1 = PCX.
- `b_sel` output 1: ALU B source; 0 = rs2, 1 = imm.
- `imm_sel` output 3: immediate format; 0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- `alu_sel` output 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- `mem_we` output 1: data-memory write enable, M stage.
- `wb_sel` output 2: M-stage write-back source; 00 mem, 01 ALU, 10 PC+4.
- `RF_we` output 1: register-file write enable, W stage.
- `ill_op` output 1: one-cycle pulse for an illegal, unsquashed X-stage instruction.
- `retire_cnt` output 32: retired instruction count (see Configuration).
- `squash_cnt` output 32: squashed instruction count (see Configuration).

## Operation
- **Supported opcodes.** R 0110011, OP-IMM 0010011, LW 0000011, SW 0100011, BRANCH 1100011 (BEQ and BNE only), JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- **Bubble.** `32'h0` is a bubble: all enables are 0 and `ill_op` is 0.
- **X-stage valid.** `x_valid` = (`kill_cnt` == 0) and (opcode legal).
- **Illegal instruction.** Any other opcode, a BRANCH with funct3 other than 000/001, or OP/OP-IMM with an undefined funct3/funct7 is illegal. It is then treated as a bubble and pulses `ill_op` (unless squashed).
- **ALU decode.** ADD/SUB and SRL/SRA use funct7[5]. OP-IMM uses funct7[5] only for shifts. LW, SW, JALR, JAL, AUIPC and BRANCH use ADD. LUI uses PASS_B.
- **Operand muxes.** `a_sel` = 1 for JAL, AUIPC and BRANCH. `b_sel` = 1 for everything except R-type.
- **Redirect.** `pc_sel` = `x_valid` and (JAL, or JALR, or BEQ with `beq` = 1, or BNE with `beq` = 0). The ALU result is used as the target unmodified; JALR bit 0 is not cleared.
- **Kill counter.** On `pc_sel` = 1, `kill_cnt` loads `KILL_DEPTH`. Otherwise it decrements toward 0.
- **Squashed instructions.** An instruction in X while `kill_cnt` != 0 has every X, M and W enable forced to 0, including `pc_sel`.
  - A squashed instruction never reloads the counter, so counter windows never overlap.
- **M-stage register.** Captures `m_mem_we` (SW and valid), `m_wb_sel` (LW → 00; JAL/JALR → 10; else 01) and `m_rf_we`. `m_rf_we` = valid, and not SW or BRANCH, and rd != 0.
- **W-stage register.** Captures `w_rf_we` from `m_rf_we`.

## Timing
- **X controls are combinational from `insx_op`.** `pc_sel`, `a_sel`, `b_sel`, `imm_sel`, `alu_sel` and `ill_op`.
- **M controls are registered.** `mem_we` and `wb_sel` appear one cycle after X.
- **W control is registered again.** `RF_we` appears two cycles after X.
- **Redirect sequence.** A redirect at cycle t means the PC loads the target at t+1. The instructions in X at t+1 and t+2 are squashed, and the target instruction reaches X at t+3.
- **Reset, asynchronous.**
  - `kill_cnt` = 0.
  - `m_mem_we` = 0, `m_rf_we` = 0, `m_wb_sel` = 01.
  - `w_rf_we` = 0.
  - Both counters = 0.
  - Combinational outputs reflect `insx_op`, which is 0 under datapath reset, so they decode as a bubble.
- **Reset mid-redirect.** Reset clears `kill_cnt` immediately. No squash persists past reset.
- **Non-redirecting branch.** A not-taken branch causes no squash and no bubble.
- **Ignored inputs.** `beq` is ignored for all non-BRANCH instructions.

## Configuration
- **`PIPE_CTRL_PERF_EN` defined.**
  - `retire_cnt` increments in every cycle where an unsquashed, legal, non-bubble instruction leaves X.
  - `squash_cnt` increments in every cycle where `kill_cnt` != 0 and `insx_op` is not a bubble.
  - Both are 32-bit, wrap modulo 2^32, and are reset to 0.
- **Not defined.** Both outputs are tied to 0 and no counter flops are synthesised.

## Test plan
- **R-type write-back.** ADD x3,x1,x2 (0x002081B3) in X → `alu_sel` = 0, `b_sel` = 0, `pc_sel` = 0; next cycle `wb_sel` = 01; following cycle `RF_we` = 1.
- **Store.** SW x2,4(x1) (0x0020A223) → `imm_sel` = 1, `b_sel` = 1; `mem_we` = 1 one cycle later; `RF_we` = 0 two cycles later.
- **Taken branch.** BEQ (0x00208463) with `beq` = 1 at t → `pc_sel` = 1. ADDI x5,x0,1 in X at t+1 and t+2 → `pc_sel` = 0, `mem_we` and `RF_we` stay 0 for them. The instruction at t+3 executes normally, and `squash_cnt` increases by 2 when `PIPE_CTRL_PERF_EN` is set.
- **Not-taken branch.** BNE (0x00209463) with `beq` = 1 → `pc_sel` = 0, no squash; the next instruction writes back.
- **Jump-and-link.** JAL x1,+8 (0x008000EF) → `pc_sel` = 1, `a_sel` = 1, `imm_sel` = 3; `wb_sel` = 10 at M; `RF_we` = 1 at W. ADDI x0,x0,0 → `RF_we` = 0 (rd = x0).
- **Reset and illegal opcode.** Assert `rest` at t+1 during a redirect → `kill_cnt`, `mem_we` and `RF_we` go to 0 asynchronously. Opcode 0x0000007F in X → `ill_op` = 1 for one cycle and no enables asserted.
